mesi_receptor: RTL and testbench

//  Snoop-side (receiver) half of the MESI protocol. Holds the MESI state of every

---
 rtl/mesi_receptor.sv | 187 ++++++++++++++++++
 tb/tb_mesi_receptor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_receptor.sv
// mesi_receptor: snoop-side half of a MESI cache controller.
// Holds the MESI state of every line of one cache. It answers rm/wm bus
// snoops by downgrading or invalidating the addressed line, and it runs a
// write-back handshake when the snooped line is Modified. The local emitter
// shares the same state table through the loc_* port.
module mesi_receptor #(
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_valid,
    output logic              bus_ready,
    input  logic [1:0]        bus_msg,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic              shared,
    output logic              wb_req,
    output logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_ack,
    output logic              snoop_done,
    output logic              snoop_inval,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [1:0]        loc_estado,
    output logic [1:0]        loc_estado_q
);

    localparam int NLINES = 1 << ADDR_W;

    // Line state encoding, shared with the local emitter
    localparam logic [1:0] ST_M = 2'b00;
    localparam logic [1:0] ST_E = 2'b01;
    localparam logic [1:0] ST_S = 2'b10;
    localparam logic [1:0] ST_I = 2'b11;

    // Bus message encoding
    localparam logic [1:0] MSG_RH = 2'b00;
    localparam logic [1:0] MSG_RM = 2'b01;
    localparam logic [1:0] MSG_WH = 2'b10;
    localparam logic [1:0] MSG_WM = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        WB_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q;
    logic [1:0]          lineTbl_q [NLINES];
    logic [1:0]          msg_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          nxt_q;
    logic                inval_q;

    logic                busReady_q;
    logic                shared_q;
    logic                wbReq_q;
    logic [ADDR_W-1:0]   wbAddr_q;
    logic                snoopDone_q;
    logic                snoopInval_q;

    logic [1:0]          curS_d;
    logic [1:0]          nxtS_d;
    logic                needWb_d;
    logic                snoopWr_d;
    logic                invalS_d;
    logic [1:0]          fwdS_d;

    // Decide what the snooped line becomes, and whether memory must get the dirty data first
    always_comb begin
        curS_d    = lineTbl_q[addr_q];
        nxtS_d    = curS_d;
        needWb_d  = 1'b0;
        snoopWr_d = 1'b0;
        case (msg_q)
            MSG_RM: begin
                snoopWr_d = 1'b1;
                needWb_d  = (curS_d == ST_M);
                nxtS_d    = (curS_d == ST_I) ? ST_I : ST_S;
            end
            MSG_WM: begin
                snoopWr_d = 1'b1;
                needWb_d  = (curS_d == ST_M);
                nxtS_d    = ST_I;
            end
            MSG_RH, MSG_WH: begin
                snoopWr_d = 1'b0;
            end
            default: begin
                snoopWr_d = 1'b0;
            end
        endcase
        invalS_d = (curS_d != ST_I) && (nxtS_d == ST_I);
    end

    // The value LOOKUP will see: a local write on the accept edge lands before the lookup,
    // so shared (registered on the accept edge) must already reflect it
    always_comb begin
        fwdS_d = lineTbl_q[bus_addr];
        if (loc_we && (loc_addr == bus_addr)) begin
            fwdS_d = loc_estado;
        end
    end

    // Snoop sequencer and state table; the snoop write comes last so it wins a same-index clash
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            msg_q        <= MSG_RH;
            addr_q       <= '0;
            nxt_q        <= ST_I;
            inval_q      <= 1'b0;
            busReady_q   <= 1'b0;
            shared_q     <= 1'b0;
            wbReq_q      <= 1'b0;
            wbAddr_q     <= '0;
            snoopDone_q  <= 1'b0;
            snoopInval_q <= 1'b0;
            for (int i = 0; i < NLINES; i++) begin
                lineTbl_q[i] <= ST_I;
            end
        end else begin
            busReady_q   <= 1'b0;
            shared_q     <= 1'b0;
            snoopDone_q  <= 1'b0;
            snoopInval_q <= 1'b0;

            if (loc_we) begin
                lineTbl_q[loc_addr] <= loc_estado;
            end

            case (state_q)
                IDLE: begin
                    if (bus_valid && busReady_q) begin
                        msg_q    <= bus_msg;
                        addr_q   <= bus_addr;
                        shared_q <= (bus_msg == MSG_RM) && (fwdS_d != ST_I);
                        state_q  <= LOOKUP;
                    end else begin
                        busReady_q <= 1'b1;
                    end
                end
                LOOKUP: begin
                    nxt_q   <= nxtS_d;
                    inval_q <= invalS_d;
                    if (needWb_d) begin
                        wbReq_q  <= 1'b1;
                        wbAddr_q <= addr_q;
                        state_q  <= WB_WAIT;
                    end else begin
                        if (snoopWr_d) begin
                            lineTbl_q[addr_q] <= nxtS_d;
                        end
                        snoopDone_q  <= 1'b1;
                        snoopInval_q <= invalS_d;
                        state_q      <= DONE;
                    end
                end
                WB_WAIT: begin
                    if (wb_ack) begin
                        lineTbl_q[addr_q] <= nxt_q;
                        wbReq_q           <= 1'b0;
                        snoopDone_q       <= 1'b1;
                        snoopInval_q      <= inval_q;
                        state_q           <= DONE;
                    end
                end
                DONE: begin
                    busReady_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus_ready    = busReady_q;
    assign shared       = shared_q;
    assign wb_req       = wbReq_q;
    assign wb_addr      = wbAddr_q;
    assign snoop_done   = snoopDone_q;
    assign snoop_inval  = snoopInval_q;
    assign loc_estado_q = lineTbl_q[loc_addr];

endmodule

// File: tb/tb_mesi_receptor.sv
// tb_mesi_receptor: directed scenarios followed by random snoops, all checked
// against a simple array model of the line states kept in the bench.
module tb_mesi_receptor;

    localparam logic [1:0] M  = 2'b00;
    localparam logic [1:0] E  = 2'b01;
    localparam logic [1:0] S  = 2'b10;
    localparam logic [1:0] I  = 2'b11;
    localparam logic [1:0] RH = 2'b00;
    localparam logic [1:0] RM = 2'b01;
    localparam logic [1:0] WH = 2'b10;
    localparam logic [1:0] WM = 2'b11;

    logic       clock = 1'b0;
    logic       reset;
    logic       bus_valid;
    logic       bus_ready;
    logic [1:0] bus_msg;
    logic [1:0] bus_addr;
    logic       shared;
    logic       wb_req;
    logic [1:0] wb_addr;
    logic       wb_ack;
    logic       snoop_done;
    logic       snoop_inval;
    logic       loc_we;
    logic [1:0] loc_addr;
    logic [1:0] loc_estado;
    logic [1:0] loc_estado_q;

    int nChecks = 0;
    int nFails  = 0;
    logic [1:0] model [4];

    mesi_receptor #(.ADDR_W(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_msg      (bus_msg),
        .bus_addr     (bus_addr),
        .shared       (shared),
        .wb_req       (wb_req),
        .wb_addr      (wb_addr),
        .wb_ack       (wb_ack),
        .snoop_done   (snoop_done),
        .snoop_inval  (snoop_inval),
        .loc_we       (loc_we),
        .loc_addr     (loc_addr),
        .loc_estado   (loc_estado),
        .loc_estado_q (loc_estado_q)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clock = ~clock;

    // Watchdog so a stuck handshake can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // What a snoop turns a line into, straight from the MESI rules
    function automatic logic [1:0] expectNext(input logic [1:0] msg, input logic [1:0] cur);
        if (msg == RM) return (cur == I) ? I : S;
        if (msg == WM) return I;
        return cur;
    endfunction

    // Read every line through the local port and compare with the model; ends on a negedge
    task automatic checkTable(input string tag);
        for (int i = 0; i < 4; i++) begin
            loc_addr = 2'(i);
            #1;
            checkOutput($sformatf("%s table[%0d]", tag, i), 32'(loc_estado_q), 32'(model[i]));
        end
        @(negedge clock);
    endtask

    // Local emitter write while the receiver is idle
    task automatic locWrite(input logic [1:0] a, input logic [1:0] s);
        loc_we     = 1'b1;
        loc_addr   = a;
        loc_estado = s;
        @(negedge clock);
        loc_we   = 1'b0;
        model[a] = s;
    endtask

    // One complete snoop, with an optional local write landing on the LOOKUP edge
    task automatic applyStimulus(input string tag, input logic [1:0] msg, input logic [1:0] a,
                                 input int ackWait, input bit doLoc,
                                 input logic [1:0] locA, input logic [1:0] locS);
        logic [1:0] cur;
        logic [1:0] nxt;
        logic       wbExp;
        logic       shExp;
        logic       invExp;
        cur    = model[a];
        nxt    = expectNext(msg, cur);
        wbExp  = ((msg == RM) || (msg == WM)) && (cur == M);
        shExp  = (msg == RM) && (cur != I);
        invExp = (cur != I) && (nxt == I);

        checkOutput({tag, " ready_before"}, 32'(bus_ready), 32'd1);
        bus_valid = 1'b1;
        bus_msg   = msg;
        bus_addr  = a;
        @(negedge clock);
        bus_valid = 1'b0;
        checkOutput({tag, " lookup_ready"}, 32'(bus_ready), 32'd0);
        checkOutput({tag, " shared"}, 32'(shared), 32'(shExp));
        checkOutput({tag, " done_early"}, 32'(snoop_done), 32'd0);
        if (doLoc) begin
            loc_we     = 1'b1;
            loc_addr   = locA;
            loc_estado = locS;
        end
        @(negedge clock);
        loc_we = 1'b0;
        if (doLoc) model[locA] = locS;
        if (wbExp) begin
            for (int k = 0; k <= ackWait; k++) begin
                checkOutput({tag, " wb_req"}, 32'(wb_req), 32'd1);
                checkOutput({tag, " wb_addr"}, 32'(wb_addr), 32'(a));
                checkOutput({tag, " wb_done_early"}, 32'(snoop_done), 32'd0);
                if (k == ackWait) wb_ack = 1'b1;
                @(negedge clock);
            end
            wb_ack = 1'b0;
        end
        if ((msg == RM) || (msg == WM)) model[a] = nxt;
        checkOutput({tag, " snoop_done"}, 32'(snoop_done), 32'd1);
        checkOutput({tag, " snoop_inval"}, 32'(snoop_inval), 32'(invExp));
        checkOutput({tag, " wb_req_done"}, 32'(wb_req), 32'd0);
        checkOutput({tag, " shared_done"}, 32'(shared), 32'd0);
        @(negedge clock);
        checkOutput({tag, " done_pulse"}, 32'(snoop_done), 32'd0);
        checkOutput({tag, " ready_after"}, 32'(bus_ready), 32'd1);
        checkTable(tag);
    endtask

    initial begin
        logic [1:0] rMsg, rA, rLocA, rLocS;
        bit         rDoLoc;
        int         op;

        reset      = 1'b1;
        bus_valid  = 1'b0;
        bus_msg    = RH;
        bus_addr   = 2'd0;
        wb_ack     = 1'b0;
        loc_we     = 1'b0;
        loc_addr   = 2'd0;
        loc_estado = I;
        for (int i = 0; i < 4; i++) model[i] = I;

        // Reset state
        repeat (2) @(negedge clock);
        checkOutput("rst bus_ready", 32'(bus_ready), 32'd0);
        checkOutput("rst wb_req", 32'(wb_req), 32'd0);
        checkOutput("rst wb_addr", 32'(wb_addr), 32'd0);
        checkOutput("rst shared", 32'(shared), 32'd0);
        checkOutput("rst snoop_done", 32'(snoop_done), 32'd0);
        checkOutput("rst snoop_inval", 32'(snoop_inval), 32'd0);
        checkTable("rst");
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rst release ready", 32'(bus_ready), 32'd1);

        // Scenario 1: rm on an Exclusive line downgrades to Shared, no write-back
        locWrite(2'd1, E);
        applyStimulus("s1", RM, 2'd1, 0, 1'b0, 2'd0, I);

        // Scenario 2: wm on a Modified line, write-back held three cycles before ack
        locWrite(2'd2, M);
        applyStimulus("s2", WM, 2'd2, 3, 1'b0, 2'd0, I);

        // Scenario 3: rm on an Invalid line changes nothing
        applyStimulus("s3", RM, 2'd0, 0, 1'b0, 2'd0, I);

        // Scenario 4: local write clashing with the snoop write, then one to another line
        locWrite(2'd3, S);
        applyStimulus("s4a", WM, 2'd3, 0, 1'b1, 2'd3, M);
        locWrite(2'd3, S);
        applyStimulus("s4b", WM, 2'd3, 0, 1'b1, 2'd0, E);

        // Scenario 6: read/write hits are ignored even on a Modified line
        locWrite(2'd2, M);
        applyStimulus("s6rh", RH, 2'd2, 0, 1'b0, 2'd0, I);
        applyStimulus("s6wh", WH, 2'd2, 0, 1'b0, 2'd0, I);

        // Scenario 5: reset asserted while waiting for the write-back ack
        locWrite(2'd1, M);
        bus_valid = 1'b1;
        bus_msg   = RM;
        bus_addr  = 2'd1;
        @(negedge clock);
        bus_valid = 1'b0;
        checkOutput("s5 shared", 32'(shared), 32'd1);
        @(negedge clock);
        checkOutput("s5 wb_req", 32'(wb_req), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("s5 wb_req dropped", 32'(wb_req), 32'd0);
        checkOutput("s5 ready in reset", 32'(bus_ready), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = I;
        @(negedge clock);
        checkOutput("s5 ready after", 32'(bus_ready), 32'd1);
        checkOutput("s5 wb_addr", 32'(wb_addr), 32'd0);
        checkTable("s5");

        // Random mix of local writes, snoops and stray acks
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 3);
            if (op == 0) begin
                locWrite(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end else if (op == 3) begin
                wb_ack = 1'b1;
                @(negedge clock);
                wb_ack = 1'b0;
                checkOutput("rnd stray ack wb_req", 32'(wb_req), 32'd0);
                checkOutput("rnd stray ack ready", 32'(bus_ready), 32'd1);
            end else begin
                rMsg   = 2'($urandom_range(0, 3));
                rA     = 2'($urandom_range(0, 3));
                rLocA  = 2'($urandom_range(0, 3));
                rLocS  = 2'($urandom_range(0, 3));
                rDoLoc = ($urandom_range(0, 1) == 1) && (rLocA != rA);
                applyStimulus($sformatf("rnd%0d", it), rMsg, rA, $urandom_range(0, 3), rDoLoc, rLocA, rLocS);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
